// File: rtl/video_stream_pkg.sv
// rtl/video_stream_pkg.sv - shared types and default geometry for the frame stream source
package video_stream_pkg;

  localparam int DEFAULT_IMG_WIDTH  = 320;
  localparam int DEFAULT_IMG_LENGTH = 240;
  localparam int PIXEL_W            = 12;

  typedef logic [PIXEL_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } src_state_t;

  typedef struct packed {
    pixel_t data;
    logic   sop;
    logic   eop;
  } beat_t;

endpackage

// File: rtl/stream_skid_fifo.sv
// rtl/stream_skid_fifo.sv - two-entry beat FIFO absorbing RAM read latency under backpressure
module stream_skid_fifo
  import video_stream_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       push_i,
  input  beat_t      push_beat_i,
  input  logic       pop_i,
  output beat_t      head_o,
  output logic [1:0] count_o
);

  beat_t      mem_q [2];
  logic       wr_q;
  logic       rd_q;
  logic [1:0] count_q;

  // Storage, pointers and occupancy; the producer never pushes into a full FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= push_beat_i;
        wr_q        <= ~wr_q;
      end
      if (pop_i) begin
        rd_q <= ~rd_q;
      end
      count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;

endmodule

// File: rtl/frame_stream_source.sv
// rtl/frame_stream_source.sv - streams one raster-order frame from a 1-cycle RAM per start pulse; macro TEST_PATTERN_EN adds test_pattern input
module frame_stream_source
  import video_stream_pkg::*;
#(
  parameter int IMG_WIDTH  = DEFAULT_IMG_WIDTH,
  parameter int IMG_LENGTH = DEFAULT_IMG_LENGTH,
  parameter int DATA_W     = PIXEL_W,
  parameter int ADDR_W     = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
`ifdef TEST_PATTERN_EN
  input  logic              test_pattern,
`endif
  output logic              busy,
  output logic              frame_done,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              ready,
  output logic              valid,
  output logic              startofpacket,
  output logic              endofpacket,
  output logic [DATA_W-1:0] data
);

  localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int YW = (IMG_LENGTH > 1) ? $clog2(IMG_LENGTH) : 1;

  src_state_t        state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic              inflight_q;
  logic              sop_q;
  logic              eop_q;
  logic              first_px;
  logic              last_px;
  logic              issue;
  logic              push;
  logic              pop;
  logic [2:0]        occupancy;
  logic [1:0]        fifo_count;
  logic [ADDR_W-1:0] cur_addr;
  pixel_t            push_pix;
  beat_t             push_beat;
  beat_t             head;

  assign cur_addr = ADDR_W'(y_q) * ADDR_W'(IMG_WIDTH) + ADDR_W'(x_q);
  assign first_px = (x_q == '0) && (y_q == '0);
  assign last_px  = (x_q == XW'(IMG_WIDTH - 1)) && (y_q == YW'(IMG_LENGTH - 1));

  // Slots committed next cycle: FIFO after this cycle's pop plus the read whose data lands now.
  // Counting the pop keeps 1 px/clk with ready high while never exceeding two entries.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue     = (state_q == FETCH) && (occupancy < 3'd2);
  assign push      = inflight_q;

  assign valid         = (fifo_count != 2'd0);
  assign pop           = valid && ready;
  assign data          = DATA_W'(head.data);
  assign startofpacket = valid && head.sop;
  assign endofpacket   = valid && head.eop;
  assign busy          = (state_q != IDLE);
  assign frame_done    = (state_q == DONE);
  assign rd_addr       = cur_addr;

`ifdef TEST_PATTERN_EN
  logic   tp_q;
  pixel_t pat_q;

  // Pattern mode is latched with start; the pattern pixel follows the same one-cycle path as RAM data.
  always_ff @(posedge clk) begin
    if (reset) begin
      tp_q  <= 1'b0;
      pat_q <= '0;
    end else begin
      if ((state_q == IDLE) && start) tp_q <= test_pattern;
      if (issue) pat_q <= pixel_t'(cur_addr);
    end
  end

  assign rd_en    = issue && !tp_q;
  assign push_pix = tp_q ? pat_q : pixel_t'(rd_data);
`else
  assign rd_en    = issue;
  assign push_pix = pixel_t'(rd_data);
`endif

  // Beat entering the FIFO: returned pixel plus the tags captured when its read was issued.
  always_comb begin
    push_beat      = '0;
    push_beat.data = push_pix;
    push_beat.sop  = sop_q;
    push_beat.eop  = eop_q;
  end

  stream_skid_fifo u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_beat_i (push_beat),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (fifo_count)
  );

  // Frame sequencing and raster counters advance on every issued read.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    case (state_q)
      IDLE:  if (start) state_d = FETCH;
      FETCH: begin
        if (issue) begin
          if (last_px) begin
            state_d = DRAIN;
            x_d     = '0;
            y_d     = '0;
          end else if (x_q == XW'(IMG_WIDTH - 1)) begin
            x_d = '0;
            y_d = y_q + YW'(1);
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end
      DRAIN: if (pop && head.eop) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counters and the tags of the read currently in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      inflight_q <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      inflight_q <= issue;
      if (issue) begin
        sop_q <= first_px;
        eop_q <= last_px;
      end
    end
  end

endmodule

// File: tb/tb_frame_stream_source.sv
// tb/tb_frame_stream_source.sv - scoreboard bench for frame_stream_source
module tb_frame_stream_source;

  localparam int W  = 80;
  localparam int L  = 60;
  localparam int N  = W * L;
  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          reset, start, ready, tp;
  logic [11:0]   rd_data = '0;
  logic          busy, frame_done, rd_en, valid, sop, eop;
  logic [AW-1:0] rd_addr;
  logic [11:0]   data;

  logic          start1, ready1;
  logic [11:0]   rd_data1 = '0;
  logic          busy1, done1, rd_en1, valid1, sop1, eop1;
  logic [AW-1:0] rd_addr1;
  logic [11:0]   data1;

  int            checks   = 0;
  int            failures = 0;
  int            ram_mode = 0;
  logic [13:0]   expq[$];

  always #5 clk = ~clk;

  frame_stream_source #(.IMG_WIDTH(W), .IMG_LENGTH(L), .DATA_W(12), .ADDR_W(AW)) u_dut (
    .clk(clk), .reset(reset), .start(start),
`ifdef TEST_PATTERN_EN
    .test_pattern(tp),
`endif
    .busy(busy), .frame_done(frame_done), .rd_addr(rd_addr), .rd_en(rd_en),
    .rd_data(rd_data), .ready(ready), .valid(valid), .startofpacket(sop),
    .endofpacket(eop), .data(data)
  );

  frame_stream_source #(.IMG_WIDTH(1), .IMG_LENGTH(1), .DATA_W(12), .ADDR_W(AW)) u_one (
    .clk(clk), .reset(reset), .start(start1),
`ifdef TEST_PATTERN_EN
    .test_pattern(1'b0),
`endif
    .busy(busy1), .frame_done(done1), .rd_addr(rd_addr1), .rd_en(rd_en1),
    .rd_data(rd_data1), .ready(ready1), .valid(valid1), .startofpacket(sop1),
    .endofpacket(eop1), .data(data1)
  );

  // 1-cycle-latency RAM models
  always @(posedge clk) begin
    if (rd_en) rd_data <= (ram_mode == 0) ? 12'h001 : rd_addr[11:0];
    if (rd_en1) rd_data1 <= (rd_addr1 == '0) ? 12'hABC : 12'h000;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_frame(input string tag, input int rpct, input int stall_n,
                           input int mid_beat, input int abort_beat, input bit use_tp);
    int          beats, dones, rd_cnt;
    bit          stalled, fin, after_done;
    logic [13:0] held, exp, obs;
    expq.delete();
    for (int k = 0; k < N; k++) begin
      logic [11:0] d;
      d = (use_tp || ram_mode == 1) ? 12'(k) : 12'h001;
      expq.push_back({d, k == 0, k == N - 1});
    end
    tp = use_tp; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; tp = 1'b0;
    beats = 0; dones = 0; rd_cnt = 0; stalled = 0; fin = 0; after_done = 0; held = '0;
    for (int cyc = 0; cyc < 4 * N + 400 && !fin; cyc++) begin
      start = 1'b0;
      if (after_done) begin
        chk({tag, " busy_after_done"}, busy, 0);
        chk({tag, " done_one_cycle"}, frame_done, 0);
        fin = 1;
      end else begin
        ready = (cyc < stall_n) ? 1'b0 : ($urandom_range(0, 99) < rpct);
        obs = {data, sop, eop};
        if (stalled) begin
          chk({tag, " hold_valid"}, valid, 1);
          chk({tag, " hold_beat"}, obs, held);
        end
        if (use_tp) chk({tag, " tp_rd_en"}, rd_en, 0);
        if (cyc < stall_n && rd_en) rd_cnt++;
        if (cyc == stall_n - 1) begin
          chk({tag, " stall_reads"}, rd_cnt <= 2, 1);
          chk({tag, " stall_valid"}, valid, 1);
          chk({tag, " stall_first"}, obs, expq[0]);
        end
        if (frame_done) begin
          dones++;
          after_done = 1;
          ready = 1'b1;
          start = 1'b1;
        end
        if (valid && ready) begin
          if (expq.size() == 0) chk({tag, " extra_beat"}, beats, N);
          else begin
            exp = expq.pop_front();
            chk({tag, " beat"}, obs, exp);
          end
          beats++;
          if (beats == mid_beat) start = 1'b1;
          if (beats == abort_beat) fin = 1;
        end
        stalled = valid && !ready;
        held = obs;
      end
      if (!fin) begin
        @(posedge clk); #1;
      end
    end
    chk({tag, " finished"}, fin, 1);
    if (abort_beat < 0) begin
      chk({tag, " beat_count"}, beats, N);
      chk({tag, " done_count"}, dones, 1);
      chk({tag, " queue_empty"}, expq.size(), 0);
    end
    start = 1'b0;
  endtask

  initial begin
    int b1, d1;
    reset = 1'b1; start = 1'b0; ready = 1'b0; tp = 1'b0; start1 = 1'b0; ready1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", busy, 0);
    chk("rst frame_done", frame_done, 0);
    chk("rst valid", valid, 0);
    chk("rst sop", sop, 0);
    chk("rst eop", eop, 0);
    chk("rst rd_en", rd_en, 0);
    chk("rst data", data, 0);
    chk("rst rd_addr", rd_addr, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    b1 = 0; d1 = 0;
    for (int c = 0; c < 12; c++) begin
      if (valid1) begin
        chk("one sop", sop1, 1);
        chk("one eop", eop1, 1);
        chk("one data", data1, 12'hABC);
        b1++;
      end
      if (done1) d1++;
      @(posedge clk); #1;
    end
    chk("one beats", b1, 1);
    chk("one dones", d1, 1);
    chk("one busy", busy1, 0);

    ram_mode = 0;
    run_frame("f1_ones", 100, 0, -1, -1, 1'b0);
    ram_mode = 1;
    run_frame("f2_rand", 50, 0, -1, -1, 1'b0);
    ram_mode = 0;
    run_frame("f3_stall", 100, 100, -1, -1, 1'b0);
    ram_mode = 1;
    run_frame("f4_midstart", 100, 0, 500, -1, 1'b0);
    run_frame("f5_abort", 100, 0, -1, 1000, 1'b0);

    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort valid", valid, 0);
    chk("abort busy", busy, 0);
    for (int c = 0; c < 5; c++) begin
      chk("abort no_done", frame_done, 0);
      chk("abort no_valid", valid, 0);
      @(posedge clk); #1;
    end
    ram_mode = 0;
    run_frame("f6_after_reset", 100, 0, -1, -1, 1'b0);

`ifdef TEST_PATTERN_EN
    ram_mode = 0;
    run_frame("f7_pattern", 50, 0, -1, -1, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
